ping_sequencer: RTL and testbench

Sequences one sonar measurement cycle: drives the transducer burst, blanks the receiver during ring-down, times the echo and reports time-of-flight in clock cycles. Sits between the top-level trigger logic and the transmit driver/echo detector; its result feeds the distance conversion stage. All timing is derived from a single elapsed-cycle counter started at the first transmit cycle.

---
 rtl/sonar_pkg.sv | 19 +
 rtl/ping_sequencer_phase_timer.sv | 38 +++
 rtl/ping_sequencer.sv | 138 +++++++++++++
 tb/tb_ping_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/sonar_pkg.sv
// Shared sonar definitions: ping sequencer state type and default timing constants
// (also consumed by the distance converter).
package sonar_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TX,
        ST_BLANK,
        ST_LISTEN,
        ST_REPORT,
        ST_HOLDOFF
    } ping_state_t;

    localparam int unsigned DEF_TX_CYCLES      = 25000;
    localparam int unsigned DEF_BLANK_CYCLES   = 50000;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 2500000;
    localparam int unsigned DEF_HOLDOFF_CYCLES = 1000000;

endpackage

// File: rtl/ping_sequencer_phase_timer.sv
// phase_timer: up-counter with synchronous clear (priority over enable) and a
// terminal-value compare against a caller-supplied limit.
module phase_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] term_val_i,
    output logic [W-1:0] count_o,
    output logic         term_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign term_o  = (count_q == term_val_i);

endmodule

// File: rtl/ping_sequencer.sv
// ping_sequencer: one sonar measurement cycle (burst, blanking, echo timing, report, holdoff).
// Define PING_AUTO_REPEAT_EN to free-run pings without start_in.
module ping_sequencer
    import sonar_pkg::*;
#(
    parameter int unsigned TX_CYCLES      = DEF_TX_CYCLES,
    parameter int unsigned BLANK_CYCLES   = DEF_BLANK_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
    parameter int unsigned TOF_WIDTH      = $clog2(TIMEOUT_CYCLES)
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 start_in,
    input  logic                 echo_in,
    output logic                 tx_en_out,
    output logic                 busy_out,
    output logic                 tof_valid_out,
    output logic [TOF_WIDTH-1:0] tof_out,
    output logic                 timeout_out
);

    if (TX_CYCLES < 1 || BLANK_CYCLES < 1 || HOLDOFF_CYCLES < 1 ||
        TX_CYCLES + BLANK_CYCLES >= TIMEOUT_CYCLES ||
        64'(HOLDOFF_CYCLES) > (64'(1) << TOF_WIDTH)) begin : g_param_check
        $error("ping_sequencer: illegal timing parameters");
    end

    ping_state_t          state_q, state_d;
    logic                 echo_q;
    logic                 tx_en_q, busy_q, tof_valid_q, timeout_q;
    logic                 timeout_d;
    logic [TOF_WIDTH-1:0] tof_q, tof_d;

    logic                 go;
    logic                 echo_edge;
    logic                 tmr_clr, tmr_en, tmr_term;
    logic [TOF_WIDTH-1:0] tmr_term_val;
    logic [TOF_WIDTH-1:0] elapsed;

`ifdef PING_AUTO_REPEAT_EN
    logic unused_start;
    assign unused_start = start_in;
    assign go           = 1'b1;
`else
    assign go = start_in;
`endif

    assign echo_edge = echo_in & ~echo_q;

    phase_timer #(.W(TOF_WIDTH)) u_timer (
        .clk_i      (clk_in),
        .rst_i      (rst_in),
        .clr_i      (tmr_clr),
        .en_i       (tmr_en),
        .term_val_i (tmr_term_val),
        .count_o    (elapsed),
        .term_o     (tmr_term)
    );

    // One shared counter: the terminal value is muxed per phase.
    always_comb begin
        state_d      = state_q;
        tmr_clr      = 1'b0;
        tmr_en       = 1'b0;
        tmr_term_val = '0;
        tof_d        = tof_q;
        timeout_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    state_d = ST_TX;
                    tmr_clr = 1'b1;
                end
            end
            ST_TX: begin
                tmr_en       = 1'b1;
                tmr_term_val = TOF_WIDTH'(TX_CYCLES - 1);
                if (tmr_term) state_d = ST_BLANK;
            end
            ST_BLANK: begin
                tmr_en       = 1'b1;
                tmr_term_val = TOF_WIDTH'(TX_CYCLES + BLANK_CYCLES - 1);
                if (tmr_term) state_d = ST_LISTEN;
            end
            ST_LISTEN: begin
                tmr_en       = 1'b1;
                tmr_term_val = TOF_WIDTH'(TIMEOUT_CYCLES - 1);
                // An edge on the final cycle takes priority over the timeout.
                if (echo_edge) begin
                    state_d = ST_REPORT;
                    tof_d   = elapsed;
                end else if (tmr_term) begin
                    state_d   = ST_REPORT;
                    tof_d     = '0;
                    timeout_d = 1'b1;
                end
            end
            ST_REPORT: begin
                tmr_clr = 1'b1;
                state_d = ST_HOLDOFF;
            end
            ST_HOLDOFF: begin
                tmr_en       = 1'b1;
                tmr_term_val = TOF_WIDTH'(HOLDOFF_CYCLES - 1);
                if (tmr_term) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= ST_IDLE;
            echo_q      <= 1'b0;
            tx_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            tof_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            tof_q       <= '0;
        end else begin
            state_q     <= state_d;
            echo_q      <= echo_in;
            tx_en_q     <= (state_d == ST_TX);
            busy_q      <= (state_d != ST_IDLE);
            tof_valid_q <= (state_d == ST_REPORT);
            timeout_q   <= (state_d == ST_REPORT) && timeout_d;
            tof_q       <= tof_d;
        end
    end

    assign tx_en_out     = tx_en_q;
    assign busy_out      = busy_q;
    assign tof_valid_out = tof_valid_q;
    assign tof_out       = tof_q;
    assign timeout_out   = timeout_q;

endmodule

// File: tb/tb_ping_sequencer.sv
// Scoreboard bench for ping_sequencer with small timing parameters and randomized echo patterns.
module tb_ping_sequencer;

    localparam int TX = 4;
    localparam int BL = 6;
    localparam int TO = 40;
    localparam int HO = 5;
    localparam int TW = $clog2(TO);

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic          start_in = 1'b0;
    logic          echo_in = 1'b0;
    logic          tx_en_out;
    logic          busy_out;
    logic          tof_valid_out;
    logic [TW-1:0] tof_out;
    logic          timeout_out;

    ping_sequencer #(
        .TX_CYCLES      (TX),
        .BLANK_CYCLES   (BL),
        .TIMEOUT_CYCLES (TO),
        .HOLDOFF_CYCLES (HO)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .start_in      (start_in),
        .echo_in       (echo_in),
        .tx_en_out     (tx_en_out),
        .busy_out      (busy_out),
        .tof_valid_out (tof_valid_out),
        .tof_out       (tof_out),
        .timeout_out   (timeout_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int tof;
        int to;
        int cyc;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   next_ok = 0;
    bit   have_prev = 1'b0;
    int   last_tof = 0;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, req);
        end
    endtask

    // Reference: first 0->1 transition of the echo level inside the listen window, else timeout.
    function automatic void model(input bit [63:0] pat, output int k, output int tof, output int to);
        k   = TO - 1;
        tof = 0;
        to  = 1;
        for (int i = TX + BL; i < TO; i++) begin
            if (pat[i] && !pat[i-1]) begin
                k   = i;
                tof = i;
                to  = 0;
                break;
            end
        end
    endfunction

    function automatic bit [63:0] gen(input int kind);
        bit [63:0] p = '0;
        int a, b;
        case (kind)
            0: begin
                a = $urandom_range(0, TO - 1);
                b = a + $urandom_range(0, 7);
                for (int i = a; i <= b && i < TO; i++) p[i] = 1'b1;
            end
            1: p[$urandom_range(TX, TX + BL - 1)] = 1'b1;
            2: begin
                a = $urandom_range(TX, TX + BL - 1);
                b = $urandom_range(TX + BL, 25);
                for (int i = a; i <= b; i++) p[i] = 1'b1;
            end
            3: for (int i = 0; i < TO; i++) p[i] = ($urandom_range(0, 7) == 0);
            4: p[TO-1] = 1'b1;
            default: p = '0;
        endcase
        return p;
    endfunction

    // Called at a negedge. Echo level pat[e] is presented during the cycle with elapsed=e.
    task automatic run_ping(input bit [63:0] pat, input bit hold, input int gap,
                            input bit mid_start, input bit do_reset);
        int   kexp, tofx, tox, p;
        exp_t it;
        model(pat, kexp, tofx, tox);
        forever begin
            if (have_prev && cyc == next_ok - 2) check("busy_last_holdoff", busy_out, 1);
            if (have_prev && cyc == next_ok - 1) begin
                check("busy_idle", busy_out, 0);
                check("tof_hold", tof_out, last_tof);
            end
            if (cyc >= next_ok - 1 + gap) break;
            @(negedge clk_in);
        end
        start_in = 1'b1;
        p = cyc + 1;
        if (!do_reset) begin
            it.tof = tofx;
            it.to  = tox;
            it.cyc = p + kexp + 1;
            sbq.push_back(it);
        end
        @(negedge clk_in);
        for (int e = 0; e <= kexp; e++) begin
            check("tx_en", tx_en_out, (e < TX) ? 1 : 0);
            check("busy", busy_out, 1);
            if (!hold) start_in = mid_start && (e == 2);
            echo_in = pat[e];
            if (do_reset && e == 1) begin
                rst_in = 1'b1;
                @(negedge clk_in);
                check("rst_tx_en", tx_en_out, 0);
                check("rst_busy", busy_out, 0);
                check("rst_tof_valid", tof_valid_out, 0);
                check("rst_timeout", timeout_out, 0);
                check("rst_tof", tof_out, 0);
                rst_in    = 1'b0;
                start_in  = 1'b0;
                echo_in   = 1'b0;
                next_ok   = cyc + 1;
                have_prev = 1'b0;
                last_tof  = 0;
                return;
            end
            @(negedge clk_in);
        end
        echo_in   = 1'b0;
        next_ok   = p + kexp + HO + 3;
        have_prev = 1'b1;
        last_tof  = tofx;
    endtask

    // Monitor: pops one expectation per result strobe.
    initial begin
        exp_t it;
        forever begin
            @(negedge clk_in);
            if (tof_valid_out) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe at cycle %0d: got tof %0d, expected no strobe", cyc, tof_out);
                end else begin
                    it = sbq.pop_front();
                    check("tof", tof_out, it.tof);
                    check("timeout_flag", timeout_out, it.to);
                    check("strobe_cycle", cyc, it.cyc);
                end
            end else begin
                check("timeout_idle", timeout_out, 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        bit [63:0] pat;
        repeat (3) @(negedge clk_in);
        check("reset_tx_en", tx_en_out, 0);
        check("reset_busy", busy_out, 0);
        check("reset_tof_valid", tof_valid_out, 0);
        check("reset_timeout", timeout_out, 0);
        check("reset_tof", tof_out, 0);
        rst_in = 1'b0;
        @(negedge clk_in);
        check("idle_after_reset", busy_out, 0);
        next_ok = cyc + 1;

        pat = '0; for (int i = 15; i <= 18; i++) pat[i] = 1'b1;
        run_ping(pat, 1'b0, 0, 1'b0, 1'b0);
        pat = '0; pat[7] = 1'b1;
        run_ping(pat, 1'b0, 1, 1'b0, 1'b0);
        pat = '0; for (int i = 8; i <= 20; i++) pat[i] = 1'b1;
        run_ping(pat, 1'b0, 0, 1'b1, 1'b0);
        pat = '0; pat[TO-1] = 1'b1;
        run_ping(pat, 1'b0, 2, 1'b0, 1'b0);
        pat = '0; pat[TX+BL] = 1'b1;
        run_ping(pat, 1'b0, 0, 1'b0, 1'b0);
        pat = '0; for (int i = TX + BL - 1; i <= 30; i++) pat[i] = 1'b1;
        run_ping(pat, 1'b0, 0, 1'b0, 1'b0);

        // start_in held high: back-to-back pings
        for (int n = 0; n < 5; n++) run_ping(gen($urandom_range(0, 5)), 1'b1, 0, 1'b0, 1'b0);
        start_in = 1'b0;

        for (int n = 0; n < 20; n++)
            run_ping(gen($urandom_range(0, 5)), 1'b0, $urandom_range(0, 3),
                     1'($urandom_range(0, 1)), 1'b0);

        pat = '0; pat[20] = 1'b1;
        run_ping(pat, 1'b0, 0, 1'b0, 1'b1);
        @(negedge clk_in);
        check("idle_after_mid_reset", busy_out, 0);
        pat = '0; pat[12] = 1'b1;
        run_ping(pat, 1'b0, 0, 1'b0, 1'b0);

        for (int w = 0; w < 100 && sbq.size() > 0; w++) @(negedge clk_in);
        check("scoreboard_drained", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
